// File: rtl/controle_multiplicacao_if.sv
// Handshake and multiplier-datapath bundle for controle_multiplicacao.
// slave is the controller's view; master is the view of whatever drives it.
interface controle_multiplicacao_if;
    logic       op_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       op_ready;

    logic [7:0] mul_a;
    logic [7:0] mul_b;
    logic       mul_start;
    logic [7:0] mul_produto;
    logic       mul_done;
    logic       mul_overflow;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] resultado;
    logic       overflow;
    logic       erro_timeout;
    logic       ocupado;
    logic [7:0] n_ops;

    modport slave (
        input  op_valid, a, b, mul_produto, mul_done, mul_overflow, res_ready,
        output op_ready, mul_a, mul_b, mul_start, res_valid, resultado,
               overflow, erro_timeout, ocupado, n_ops
    );

    modport master (
        output op_valid, a, b, mul_produto, mul_done, mul_overflow, res_ready,
        input  op_ready, mul_a, mul_b, mul_start, res_valid, resultado,
               overflow, erro_timeout, ocupado, n_ops
    );
endinterface

// File: rtl/controle_multiplicacao.sv
// Sequencer for an iterative 8-bit multiplier: latches operands, runs the
// datapath under a cycle budget, saturates on overflow and holds the result.
module controle_multiplicacao #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    controle_multiplicacao_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [7:0] LAST_RUN = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] run_cnt_reg;
    logic [7:0] mul_a_reg;
    logic [7:0] mul_b_reg;
    logic       mul_start_reg;
    logic [7:0] resultado_reg;
    logic       overflow_reg;
    logic       erro_timeout_reg;
    logic [7:0] n_ops_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= IDLE;
            run_cnt_reg      <= 8'd0;
            mul_a_reg        <= 8'd0;
            mul_b_reg        <= 8'd0;
            mul_start_reg    <= 1'b0;
            resultado_reg    <= 8'd0;
            overflow_reg     <= 1'b0;
            erro_timeout_reg <= 1'b0;
            n_ops_reg        <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.op_valid) begin
                        mul_a_reg <= bus.a;
                        mul_b_reg <= bus.b;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    // mul_start rises together with the RUN state so the
                    // datapath sees operands that were stable for a full cycle.
                    run_cnt_reg   <= 8'd0;
                    mul_start_reg <= 1'b1;
                    state_reg     <= RUN;
                end
                RUN: begin
                    if (bus.mul_done) begin
                        resultado_reg    <= bus.mul_overflow ? 8'hFF : bus.mul_produto;
                        overflow_reg     <= bus.mul_overflow;
                        erro_timeout_reg <= 1'b0;
                        mul_start_reg    <= 1'b0;
                        state_reg        <= HOLD;
                    end else if (run_cnt_reg == LAST_RUN) begin
                        resultado_reg    <= 8'd0;
                        overflow_reg     <= 1'b0;
                        erro_timeout_reg <= 1'b1;
                        mul_start_reg    <= 1'b0;
                        state_reg        <= HOLD;
                    end else begin
                        run_cnt_reg <= run_cnt_reg + 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        n_ops_reg <= n_ops_reg + 8'd1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    mul_start_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode the state alone, so reset clears them at once.
    assign bus.op_ready     = (state_reg == IDLE);
    assign bus.res_valid    = (state_reg == HOLD);
    assign bus.ocupado      = (state_reg != IDLE);
    assign bus.mul_a        = mul_a_reg;
    assign bus.mul_b        = mul_b_reg;
    assign bus.mul_start    = mul_start_reg;
    assign bus.resultado    = resultado_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.erro_timeout = erro_timeout_reg;
    assign bus.n_ops        = n_ops_reg;

endmodule

// File: tb/tb_controle_multiplicacao.sv
// Scoreboard bench: a driver issues operations, a multiplier model answers
// mul_start, and a monitor compares each held result against the queue.
`timescale 1ns/1ps
module tb_controle_multiplicacao;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    controle_multiplicacao_if bus ();

    controle_multiplicacao #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
    } op_t;

    op_t exp_q[$];
    op_t mul_q[$];

    int checks      = 0;
    int failures    = 0;
    int run_cnt     = 0;
    bit abort_run   = 1'b0;
    int hold_cycles = -1;
    int results     = 0;
    int nops_model  = 0;

    function automatic void check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic int exp_run_len(int lat);
        return (lat <= TIMEOUT) ? lat : TIMEOUT;
    endfunction

    // Multiplier datapath model: answers lat cycles into the run, else noise.
    initial begin
        op_t cur;
        int  prod;
        cur.a = 8'd0; cur.b = 8'd0; cur.lat = NEVER;
        bus.mul_done = 1'b0; bus.mul_overflow = 1'b0; bus.mul_produto = 8'd0;
        forever begin
            @(negedge clk);
            if (bus.mul_start) begin
                if (run_cnt == 0) begin
                    if (mul_q.size() == 0) begin
                        failures++;
                        $display("FAIL run_without_op actual=1 required=0");
                        cur.a = 8'd0; cur.b = 8'd0; cur.lat = NEVER;
                    end else begin
                        cur = mul_q.pop_front();
                    end
                    check("mul_a", int'(bus.mul_a), int'(cur.a));
                    check("mul_b", int'(bus.mul_b), int'(cur.b));
                end
                run_cnt++;
                prod = int'(cur.a) * int'(cur.b);
                if (run_cnt == cur.lat) begin
                    bus.mul_done     = 1'b1;
                    bus.mul_produto  = prod[7:0];
                    bus.mul_overflow = (prod > 255);
                end else begin
                    bus.mul_done     = 1'b0;
                    bus.mul_produto  = 8'($urandom);
                    bus.mul_overflow = 1'($urandom);
                end
            end else begin
                if (run_cnt > 0 && !abort_run)
                    check("run_length", run_cnt, exp_run_len(cur.lat));
                run_cnt   = 0;
                abort_run = 1'b0;
                bus.mul_done     = 1'($urandom);
                bus.mul_overflow = 1'($urandom);
                bus.mul_produto  = 8'($urandom);
            end
        end
    end

    // Result monitor: pops the expected operation on the first HOLD cycle.
    initial begin
        bit   in_hold = 1'b0;
        int   hold_left = 0;
        int   prod;
        op_t  e;
        int   e_res, e_ovf, e_to;
        bus.res_ready = 1'b0;
        e.a = 8'd0; e.b = 8'd0; e.lat = NEVER;
        e_res = 0; e_ovf = 0; e_to = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                in_hold = 1'b0;
                bus.res_ready = 1'b0;
                continue;
            end
            if (bus.res_valid) begin
                if (!in_hold) begin
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_result actual=%0d required=none", bus.resultado);
                    end else begin
                        e = exp_q.pop_front();
                    end
                    prod = int'(e.a) * int'(e.b);
                    if (e.lat > TIMEOUT) begin
                        e_res = 0; e_ovf = 0; e_to = 1;
                    end else begin
                        e_ovf = (prod > 255) ? 1 : 0;
                        e_res = e_ovf ? 255 : (prod % 256);
                        e_to  = 0;
                    end
                    check("resultado", int'(bus.resultado), e_res);
                    check("overflow", int'(bus.overflow), e_ovf);
                    check("erro_timeout", int'(bus.erro_timeout), e_to);
                    $display("result a=%0d b=%0d lat=%0d resultado=%0d overflow=%0d erro_timeout=%0d n_ops=%0d",
                             e.a, e.b, e.lat, bus.resultado, bus.overflow, bus.erro_timeout, bus.n_ops);
                    in_hold   = 1'b1;
                    hold_left = (hold_cycles >= 0) ? hold_cycles : int'($urandom_range(0, 2));
                end else begin
                    check("hold_resultado", int'(bus.resultado), e_res);
                    check("hold_erro_timeout", int'(bus.erro_timeout), e_to);
                    check("hold_mul_a", int'(bus.mul_a), int'(e.a));
                    check("hold_mul_b", int'(bus.mul_b), int'(e.b));
                    check("hold_op_ready", int'(bus.op_ready), 0);
                end
                if (hold_left == 0) begin
                    check("n_ops", int'(bus.n_ops), nops_model % 256);
                    nops_model++;
                    results++;
                    in_hold = 1'b0;
                    bus.res_ready = 1'b1;
                end else begin
                    bus.res_ready = 1'b0;
                    hold_left--;
                end
            end else begin
                bus.res_ready = bus.op_ready ? 1'($urandom) : 1'b0;
            end
        end
    end

    // Called just after a negedge; returns just after the negedge after accept.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int lat);
        op_t o;
        int  tries = 0;
        while (!bus.op_ready && tries < 200) begin
            bus.op_valid = 1'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(negedge clk);
            tries++;
        end
        if (!bus.op_ready) begin
            failures++;
            $display("FAIL op_ready_wait actual=0 required=1");
        end
        o.a = a; o.b = b; o.lat = lat;
        bus.op_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        exp_q.push_back(o);
        mul_q.push_back(o);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic drain();
        int tries = 0;
        while (!(bus.op_ready && exp_q.size() == 0) && tries < 500) begin
            @(negedge clk);
            bus.op_valid = bus.op_ready ? 1'b0 : 1'($urandom);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            tries++;
        end
        check("drain_done", int'(bus.op_ready && exp_q.size() == 0), 1);
        bus.op_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         tries;
        bus.op_valid = 1'b0;
        bus.a = 8'd0;
        bus.b = 8'd0;

        #1;
        check("rst_op_ready", int'(bus.op_ready), 1);
        check("rst_mul_start", int'(bus.mul_start), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_ocupado", int'(bus.ocupado), 0);
        check("rst_n_ops", int'(bus.n_ops), 0);
        check("rst_mul_a", int'(bus.mul_a), 0);
        check("rst_resultado", int'(bus.resultado), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // First edge after release must accept; LOAD is visible one cycle on.
        do_op(8'd3, 8'd5, 8);
        check("first_accept_ocupado", int'(bus.ocupado), 1);
        check("load_mul_start", int'(bus.mul_start), 0);
        drain();
        check("n_ops_after_first", int'(bus.n_ops), 1);

        do_op(8'd20, 8'd20, 3);
        do_op(8'd7, 8'd9, NEVER);
        do_op(8'd16, 8'd16, TIMEOUT);
        do_op(8'd255, 8'd1, TIMEOUT + 1);
        hold_cycles = 5;
        do_op(8'd11, 8'd13, 2);
        drain();
        hold_cycles = -1;

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom_range(0, 255) >> $urandom_range(0, 4));
            rb = 8'($urandom_range(0, 255) >> $urandom_range(0, 4));
            do_op(ra, rb, int'($urandom_range(1, TIMEOUT + 3)));
        end
        drain();

        // Reset in the 4th run cycle must drop mul_start without an edge.
        do_op(8'd9, 8'd9, NEVER);
        tries = 0;
        while (run_cnt != 4 && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        check("reached_run4", run_cnt, 4);
        abort_run = 1'b1;
        rst = 1'b0;
        #1;
        check("async_mul_start", int'(bus.mul_start), 0);
        check("async_res_valid", int'(bus.res_valid), 0);
        check("async_op_ready", int'(bus.op_ready), 1);
        exp_q.delete();
        mul_q.delete();
        repeat (3) @(negedge clk);
        #3;
        check("rst2_n_ops", int'(bus.n_ops), 0);
        check("rst2_mul_a", int'(bus.mul_a), 0);
        check("rst2_resultado", int'(bus.resultado), 0);
        check("rst2_ocupado", int'(bus.ocupado), 0);
        @(negedge clk);
        nops_model = 0;
        rst = 1'b1;
        check("rel_op_ready", int'(bus.op_ready), 1);

        hold_cycles = 0;
        results = 0;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 3));
            do_op(ra, rb, int'($urandom_range(1, 4)));
        end
        drain();
        check("wrap_results", results, 256);
        check("wrap_n_ops", int'(bus.n_ops), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
